// File: rtl/lsu_arbiter_if.sv
// Request/response and LSU-side bundle for lsu_arbiter.
// Handshake: a request transfers in the cycle where i_reqN_valid && o_reqN_ready; payload stays stable while valid && !ready.
interface lsu_arbiter_if;
  logic        i_req0_valid;
  logic        i_req0_wren;
  logic [31:0] i_req0_addr;
  logic [3:0]  i_req0_mask;
  logic [31:0] i_req0_wdata;
  logic        o_req0_ready;
  logic        o_rsp0_valid;
  logic [31:0] o_rsp0_rdata;

  logic        i_req1_valid;
  logic        i_req1_wren;
  logic [31:0] i_req1_addr;
  logic [3:0]  i_req1_mask;
  logic [31:0] i_req1_wdata;
  logic        o_req1_ready;
  logic        o_rsp1_valid;
  logic [31:0] o_rsp1_rdata;

  logic [31:0] o_lsu_addr;
  logic        o_lsu_wren;
  logic [3:0]  o_lsu_mask;
  logic [31:0] o_lsu_stData;
  logic [31:0] i_lsu_ldData;
  logic        o_busy;
  logic [1:0]  o_dbg_state;

  modport slave (
    input  i_req0_valid, i_req0_wren, i_req0_addr, i_req0_mask, i_req0_wdata,
    input  i_req1_valid, i_req1_wren, i_req1_addr, i_req1_mask, i_req1_wdata,
    input  i_lsu_ldData,
    output o_req0_ready, o_rsp0_valid, o_rsp0_rdata,
    output o_req1_ready, o_rsp1_valid, o_rsp1_rdata,
    output o_lsu_addr, o_lsu_wren, o_lsu_mask, o_lsu_stData,
    output o_busy, o_dbg_state
  );

  modport master (
    output i_req0_valid, i_req0_wren, i_req0_addr, i_req0_mask, i_req0_wdata,
    output i_req1_valid, i_req1_wren, i_req1_addr, i_req1_mask, i_req1_wdata,
    output i_lsu_ldData,
    input  o_req0_ready, o_rsp0_valid, o_rsp0_rdata,
    input  o_req1_ready, o_rsp1_valid, o_rsp1_rdata,
    input  o_lsu_addr, o_lsu_wren, o_lsu_mask, o_lsu_stData,
    input  o_busy, o_dbg_state
  );
endinterface

// File: rtl/lsu_arbiter.sv
// Two-requester arbiter/sequencer for the single LSU port: accept, ISSUE, optional WAIT, one-cycle response.
// Build option LSU_ARB_FIXED_PRIO_EN: requester 0 always wins contention (no round-robin pointer).
module lsu_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  lsu_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] LAT = RD_LATENCY[1:0];

  state_t      r_state;
  logic        r_id;
  logic        r_wren;
  logic [1:0]  r_cnt;
  logic [31:0] r_lsu_addr;
  logic        r_lsu_wren;
  logic [3:0]  r_lsu_mask;
  logic [31:0] r_lsu_stData;
  logic        r_rsp0_valid;
  logic        r_rsp1_valid;
  logic [31:0] r_rsp0_rdata;
  logic [31:0] r_rsp1_rdata;

  logic w_idle;
  logic w_gnt0;
  logic w_gnt1;
  logic w_rdy0;
  logic w_rdy1;
  logic w_accept;

  // Ready is suppressed while reset is held so nothing is accepted during it.
  assign w_idle = (r_state == IDLE) && !i_reset;

`ifdef LSU_ARB_FIXED_PRIO_EN
  assign w_gnt0 = bus.i_req0_valid;
  assign w_gnt1 = bus.i_req1_valid && !bus.i_req0_valid;
`else
  logic r_last;
  // r_last holds the id of the last granted requester; the other one wins a tie.
  assign w_gnt1 = bus.i_req1_valid && (!bus.i_req0_valid || !r_last);
  assign w_gnt0 = bus.i_req0_valid && !w_gnt1;
`endif

  assign w_rdy0   = w_gnt0 && w_idle;
  assign w_rdy1   = w_gnt1 && w_idle;
  assign w_accept = w_rdy0 || w_rdy1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_id         <= 1'b0;
      r_wren       <= 1'b0;
      r_cnt        <= 2'd0;
      r_lsu_addr   <= 32'd0;
      r_lsu_wren   <= 1'b0;
      r_lsu_mask   <= 4'd0;
      r_lsu_stData <= 32'd0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_rdata <= 32'd0;
      r_rsp1_rdata <= 32'd0;
`ifndef LSU_ARB_FIXED_PRIO_EN
      r_last       <= 1'b1;
`endif
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_id         <= w_rdy1;
            r_wren       <= w_rdy1 ? bus.i_req1_wren  : bus.i_req0_wren;
            r_lsu_wren   <= w_rdy1 ? bus.i_req1_wren  : bus.i_req0_wren;
            r_lsu_addr   <= w_rdy1 ? bus.i_req1_addr  : bus.i_req0_addr;
            r_lsu_mask   <= w_rdy1 ? bus.i_req1_mask  : bus.i_req0_mask;
            r_lsu_stData <= w_rdy1 ? bus.i_req1_wdata : bus.i_req0_wdata;
`ifndef LSU_ARB_FIXED_PRIO_EN
            r_last       <= w_rdy1;
`endif
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_lsu_wren <= 1'b0;
          if (r_wren) begin
            r_lsu_mask <= 4'd0;
            r_state    <= IDLE;
          end else if (LAT == 2'd0) begin
            r_rsp0_valid <= !r_id;
            r_rsp1_valid <= r_id;
            if (r_id) r_rsp1_rdata <= bus.i_lsu_ldData;
            else      r_rsp0_rdata <= bus.i_lsu_ldData;
            r_lsu_mask <= 4'd0;
            r_state    <= IDLE;
          end else begin
            r_cnt   <= LAT;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 2'd1) begin
            r_rsp0_valid <= !r_id;
            r_rsp1_valid <= r_id;
            if (r_id) r_rsp1_rdata <= bus.i_lsu_ldData;
            else      r_rsp0_rdata <= bus.i_lsu_ldData;
            r_lsu_mask <= 4'd0;
            r_state    <= IDLE;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_req0_ready = w_rdy0;
  assign bus.o_req1_ready = w_rdy1;
  assign bus.o_rsp0_valid = r_rsp0_valid;
  assign bus.o_rsp1_valid = r_rsp1_valid;
  assign bus.o_rsp0_rdata = r_rsp0_rdata;
  assign bus.o_rsp1_rdata = r_rsp1_rdata;
  assign bus.o_lsu_addr   = r_lsu_addr;
  assign bus.o_lsu_wren   = r_lsu_wren;
  assign bus.o_lsu_mask   = r_lsu_mask;
  assign bus.o_lsu_stData = r_lsu_stData;
  assign bus.o_busy       = (r_state != IDLE);
  assign bus.o_dbg_state  = r_state;
endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: three instances with RD_LATENCY 1, 3 and 0 share one clock and reset.
module tb_lsu_arbiter;
`ifdef LSU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  lsu_arbiter_if if1();
  lsu_arbiter_if if3();
  lsu_arbiter_if if0();

  lsu_arbiter #(.RD_LATENCY(1)) u_dut1 (.i_clk(clk), .i_reset(rst), .bus(if1));
  lsu_arbiter #(.RD_LATENCY(3)) u_dut3 (.i_clk(clk), .i_reset(rst), .bus(if3));
  lsu_arbiter #(.RD_LATENCY(0)) u_dut0 (.i_clk(clk), .i_reset(rst), .bus(if0));

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic init_inputs();
    if1.i_req0_valid = 0; if1.i_req0_wren = 0; if1.i_req0_addr = 0; if1.i_req0_mask = 0; if1.i_req0_wdata = 0;
    if1.i_req1_valid = 0; if1.i_req1_wren = 0; if1.i_req1_addr = 0; if1.i_req1_mask = 0; if1.i_req1_wdata = 0;
    if1.i_lsu_ldData = 0;
    if3.i_req0_valid = 0; if3.i_req0_wren = 0; if3.i_req0_addr = 0; if3.i_req0_mask = 0; if3.i_req0_wdata = 0;
    if3.i_req1_valid = 0; if3.i_req1_wren = 0; if3.i_req1_addr = 0; if3.i_req1_mask = 0; if3.i_req1_wdata = 0;
    if3.i_lsu_ldData = 0;
    if0.i_req0_valid = 0; if0.i_req0_wren = 0; if0.i_req0_addr = 0; if0.i_req0_mask = 0; if0.i_req0_wdata = 0;
    if0.i_req1_valid = 0; if0.i_req1_wren = 0; if0.i_req1_addr = 0; if0.i_req1_mask = 0; if0.i_req1_wdata = 0;
    if0.i_lsu_ldData = 0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    if1.i_req0_valid = 1'b1;
    if1.i_req1_valid = 1'b1;
    #1;
    n_tests++; if (if1.o_req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready0 got=%b exp=0", if1.o_req0_ready); end
    n_tests++; if (if1.o_req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready1 got=%b exp=0", if1.o_req1_ready); end
    n_tests++; if (if1.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", if1.o_busy); end
    n_tests++; if (if1.o_lsu_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren got=%b exp=0", if1.o_lsu_wren); end
    n_tests++; if (if1.o_lsu_mask !== 4'h0) begin n_fail++; $display("FAIL reset_mask got=%h exp=0", if1.o_lsu_mask); end
    n_tests++; if (if1.o_lsu_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", if1.o_lsu_addr); end
    n_tests++; if (if1.o_lsu_stData !== 32'h0) begin n_fail++; $display("FAIL reset_stdata got=%h exp=0", if1.o_lsu_stData); end
    n_tests++; if (if1.o_rsp0_valid !== 1'b0 || if1.o_rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp got=%b%b exp=00", if1.o_rsp0_valid, if1.o_rsp1_valid); end
    n_tests++; if (if1.o_rsp0_rdata !== 32'h0 || if1.o_rsp1_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h/%h exp=0", if1.o_rsp0_rdata, if1.o_rsp1_rdata); end
    n_tests++; if (if1.o_dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", if1.o_dbg_state); end
    if1.i_req0_valid = 1'b0;
    if1.i_req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    cyc();
    if1.i_req0_valid = 1'b1; if1.i_req0_wren = 1'b1; if1.i_req0_addr = 32'h1000_0000;
    if1.i_req0_wdata = 32'hA5A5_0F0F; if1.i_req0_mask = 4'hF;
    #1;
    n_tests++; if (if1.o_req0_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready0 got=%b exp=1", if1.o_req0_ready); end
    n_tests++; if (if1.o_req1_ready !== 1'b0) begin n_fail++; $display("FAIL wr_ready1 got=%b exp=0", if1.o_req1_ready); end
    cyc();
    if1.i_req0_valid = 1'b0;
    #1;
    n_tests++; if (if1.o_lsu_wren !== 1'b1) begin n_fail++; $display("FAIL wr_issue_wren got=%b exp=1", if1.o_lsu_wren); end
    n_tests++; if (if1.o_lsu_addr !== 32'h1000_0000) begin n_fail++; $display("FAIL wr_issue_addr got=%h exp=10000000", if1.o_lsu_addr); end
    n_tests++; if (if1.o_lsu_stData !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL wr_issue_data got=%h exp=a5a50f0f", if1.o_lsu_stData); end
    n_tests++; if (if1.o_lsu_mask !== 4'hF) begin n_fail++; $display("FAIL wr_issue_mask got=%h exp=f", if1.o_lsu_mask); end
    n_tests++; if (if1.o_busy !== 1'b1) begin n_fail++; $display("FAIL wr_issue_busy got=%b exp=1", if1.o_busy); end
    cyc();
    #1;
    n_tests++; if (if1.o_lsu_wren !== 1'b0) begin n_fail++; $display("FAIL wr_after_wren got=%b exp=0", if1.o_lsu_wren); end
    n_tests++; if (if1.o_lsu_mask !== 4'h0) begin n_fail++; $display("FAIL wr_after_mask got=%h exp=0", if1.o_lsu_mask); end
    n_tests++; if (if1.o_busy !== 1'b0) begin n_fail++; $display("FAIL wr_after_busy got=%b exp=0", if1.o_busy); end
    n_tests++; if (if1.o_lsu_addr !== 32'h1000_0000) begin n_fail++; $display("FAIL wr_after_addr_hold got=%h exp=10000000", if1.o_lsu_addr); end
    n_tests++; if (if1.o_rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rsp0 got=%b exp=0", if1.o_rsp0_valid); end
    cyc();
    #1;
    n_tests++; if (if1.o_rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rsp0_late got=%b exp=0", if1.o_rsp0_valid); end
  endtask

  task automatic test_single_read();
    cyc();
    if1.i_lsu_ldData = 32'hDEAD_BEEF;
    if1.i_req1_valid = 1'b1; if1.i_req1_wren = 1'b0; if1.i_req1_addr = 32'h1001_0000; if1.i_req1_mask = 4'hF;
    #1;
    n_tests++; if (if1.o_req1_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready1 got=%b exp=1", if1.o_req1_ready); end
    n_tests++; if (if1.o_req0_ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready0 got=%b exp=0", if1.o_req0_ready); end
    for (int k = 1; k <= 4; k++) begin
      cyc();
      if (k == 1) if1.i_req1_valid = 1'b0;
      if1.i_lsu_ldData = (k == 2) ? 32'h0000_00FF : 32'hDEAD_BEEF;
      #1;
      n_tests++; if (if1.o_rsp1_valid !== (k == 3)) begin n_fail++; $display("FAIL rd_rsp1_k%0d got=%b exp=%b", k, if1.o_rsp1_valid, (k == 3)); end
      n_tests++; if (if1.o_rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL rd_rsp0_k%0d got=%b exp=0", k, if1.o_rsp0_valid); end
      if (k == 1) begin
        n_tests++; if (if1.o_lsu_wren !== 1'b0) begin n_fail++; $display("FAIL rd_issue_wren got=%b exp=0", if1.o_lsu_wren); end
        n_tests++; if (if1.o_lsu_addr !== 32'h1001_0000) begin n_fail++; $display("FAIL rd_issue_addr got=%h exp=10010000", if1.o_lsu_addr); end
      end
      if (k >= 3) begin
        n_tests++; if (if1.o_rsp1_rdata !== 32'h0000_00FF) begin n_fail++; $display("FAIL rd_rdata1_k%0d got=%h exp=000000ff", k, if1.o_rsp1_rdata); end
      end
    end
  endtask

  task automatic test_contention();
    logic exp_acc, exp_rsp;
    int   g, pg;
    if1.i_req0_wren = 1'b0; if1.i_req0_addr = 32'h2000_0000; if1.i_req0_mask = 4'hF;
    if1.i_req1_wren = 1'b0; if1.i_req1_addr = 32'h3000_0000; if1.i_req1_mask = 4'hF;
    for (int k = 0; k <= 12; k++) begin
      cyc();
      if1.i_req0_valid = (k < 12);
      if1.i_req1_valid = (k < 12);
      if1.i_lsu_ldData = 32'hC0DE_0000 + k;
      #1;
      exp_acc = (k % 3 == 0) && (k < 12);
      g       = FIXED ? 0 : (k / 3) % 2;
      exp_rsp = (k % 3 == 0) && (k > 0);
      pg      = FIXED ? 0 : ((k / 3) + 1) % 2;
      n_tests++; if (if1.o_req0_ready !== (exp_acc && g == 0)) begin n_fail++; $display("FAIL arb_ready0_k%0d got=%b exp=%b", k, if1.o_req0_ready, (exp_acc && g == 0)); end
      n_tests++; if (if1.o_req1_ready !== (exp_acc && g == 1)) begin n_fail++; $display("FAIL arb_ready1_k%0d got=%b exp=%b", k, if1.o_req1_ready, (exp_acc && g == 1)); end
      n_tests++; if (if1.o_rsp0_valid !== (exp_rsp && pg == 0)) begin n_fail++; $display("FAIL arb_rsp0_k%0d got=%b exp=%b", k, if1.o_rsp0_valid, (exp_rsp && pg == 0)); end
      n_tests++; if (if1.o_rsp1_valid !== (exp_rsp && pg == 1)) begin n_fail++; $display("FAIL arb_rsp1_k%0d got=%b exp=%b", k, if1.o_rsp1_valid, (exp_rsp && pg == 1)); end
      if (exp_rsp && pg == 0) begin
        n_tests++; if (if1.o_rsp0_rdata !== 32'hC0DE_0000 + k - 1) begin n_fail++; $display("FAIL arb_rdata0_k%0d got=%h exp=%h", k, if1.o_rsp0_rdata, 32'hC0DE_0000 + k - 1); end
      end
      if (exp_rsp && pg == 1) begin
        n_tests++; if (if1.o_rsp1_rdata !== 32'hC0DE_0000 + k - 1) begin n_fail++; $display("FAIL arb_rdata1_k%0d got=%h exp=%h", k, if1.o_rsp1_rdata, 32'hC0DE_0000 + k - 1); end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    cyc();
    if3.i_req0_valid = 1'b1; if3.i_req0_wren = 1'b1; if3.i_req0_addr = 32'h4000_0000;
    if3.i_req0_wdata = 32'h0000_0011; if3.i_req0_mask = 4'h3;
    #1;
    n_tests++; if (if3.o_req0_ready !== 1'b1) begin n_fail++; $display("FAIL rst_pre_wr_ready0 got=%b exp=1", if3.o_req0_ready); end
    cyc();
    if3.i_req0_valid = 1'b0;
    cyc();
    if3.i_req0_valid = 1'b1; if3.i_req0_wren = 1'b0; if3.i_req0_mask = 4'hF;
    if3.i_lsu_ldData = 32'h7777_7777;
    #1;
    n_tests++; if (if3.o_req0_ready !== 1'b1) begin n_fail++; $display("FAIL rst_rd_ready0 got=%b exp=1", if3.o_req0_ready); end
    cyc();
    if3.i_req0_valid = 1'b0;
    cyc();
    if3.i_req0_valid = 1'b1;
    if3.i_req1_valid = 1'b1;
    #1;
    n_tests++; if (if3.o_dbg_state !== 2'd2) begin n_fail++; $display("FAIL rst_in_wait_state got=%0d exp=2", if3.o_dbg_state); end
    n_tests++; if (if3.o_req0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wait_ready0 got=%b exp=0", if3.o_req0_ready); end
    rst = 1'b1;
    #1;
    n_tests++; if (if3.o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", if3.o_busy); end
    n_tests++; if (if3.o_lsu_wren !== 1'b0) begin n_fail++; $display("FAIL rst_wren got=%b exp=0", if3.o_lsu_wren); end
    n_tests++; if (if3.o_lsu_mask !== 4'h0) begin n_fail++; $display("FAIL rst_mask got=%h exp=0", if3.o_lsu_mask); end
    n_tests++; if (if3.o_req0_ready !== 1'b0 || if3.o_req1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b%b exp=00", if3.o_req0_ready, if3.o_req1_ready); end
    #1 rst = 1'b0;
    #1;
    n_tests++; if (if3.o_req0_ready !== 1'b1) begin n_fail++; $display("FAIL rst_next_ready0 got=%b exp=1", if3.o_req0_ready); end
    n_tests++; if (if3.o_req1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_next_ready1 got=%b exp=0", if3.o_req1_ready); end
    if3.i_req0_valid = 1'b0;
    if3.i_req1_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      #1;
      n_tests++; if (if3.o_rsp0_valid !== 1'b0 || if3.o_rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_rsp_k%0d got=%b%b exp=00", k, if3.o_rsp0_valid, if3.o_rsp1_valid); end
      n_tests++; if (if3.o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy_k%0d got=%b exp=0", k, if3.o_busy); end
    end
  endtask

  task automatic test_back_to_back();
    cyc();
    if0.i_lsu_ldData = 32'hDEAD_BEEF;
    if0.i_req0_valid = 1'b1; if0.i_req0_wren = 1'b0; if0.i_req0_addr = 32'h5000_0000; if0.i_req0_mask = 4'hF;
    #1;
    n_tests++; if (if0.o_req0_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_ready0 got=%b exp=1", if0.o_req0_ready); end
    cyc();
    if0.i_req0_wren = 1'b1; if0.i_req0_addr = 32'h5000_0004; if0.i_req0_wdata = 32'h1234_5678;
    if0.i_lsu_ldData = 32'h600D_F00D;
    #1;
    n_tests++; if (if0.o_req0_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_issue_ready0 got=%b exp=0", if0.o_req0_ready); end
    n_tests++; if (if0.o_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_issue_busy got=%b exp=1", if0.o_busy); end
    cyc();
    if0.i_lsu_ldData = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (if0.o_rsp0_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_rsp0 got=%b exp=1", if0.o_rsp0_valid); end
    n_tests++; if (if0.o_rsp0_rdata !== 32'h600D_F00D) begin n_fail++; $display("FAIL b2b_rdata0 got=%h exp=600df00d", if0.o_rsp0_rdata); end
    n_tests++; if (if0.o_req0_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_ready0 got=%b exp=1", if0.o_req0_ready); end
    cyc();
    if0.i_req0_valid = 1'b0;
    #1;
    n_tests++; if (if0.o_lsu_wren !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_wren got=%b exp=1", if0.o_lsu_wren); end
    n_tests++; if (if0.o_lsu_stData !== 32'h1234_5678) begin n_fail++; $display("FAIL b2b_wr_data got=%h exp=12345678", if0.o_lsu_stData); end
    n_tests++; if (if0.o_lsu_addr !== 32'h5000_0004) begin n_fail++; $display("FAIL b2b_wr_addr got=%h exp=50000004", if0.o_lsu_addr); end
    n_tests++; if (if0.o_rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_rsp0_once got=%b exp=0", if0.o_rsp0_valid); end
    cyc();
    #1;
    n_tests++; if (if0.o_lsu_wren !== 1'b0) begin n_fail++; $display("FAIL b2b_after_wren got=%b exp=0", if0.o_lsu_wren); end
    n_tests++; if (if0.o_rsp0_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_wr_no_rsp got=%b exp=0", if0.o_rsp0_valid); end
    n_tests++; if (if0.o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_after_busy got=%b exp=0", if0.o_busy); end
    n_tests++; if (if0.o_rsp0_rdata !== 32'h600D_F00D) begin n_fail++; $display("FAIL b2b_rdata_hold got=%h exp=600df00d", if0.o_rsp0_rdata); end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_reset_mid_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
